flash_loader: RTL and testbench

- Boot-time copy engine. Sits directly upstream of the flash driver and drives its read interface (enable_read, addr; consumes data_out, busy).
- Copies a block of 16-bit words from parallel flash into the RAM write port of the SRAM controller.
- Started by the boot FSM. Runs one transfer per start. Reports completion with a one-cycle done pulse.

---
 rtl/flash_loader_pkg.sv | 14 +
 rtl/flash_loader_if.sv | 27 ++
 rtl/flash_loader_wbuf.sv | 44 ++++
 rtl/flash_loader.sv | 121 ++++++++++++
 tb/tb_flash_loader.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flash_loader_pkg.sv
// rtl/flash_loader_pkg.sv - shared state encoding and flash address width for the boot copy engine
package flash_loader_pkg;

    localparam int FLASH_AW = 23;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        READ   = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/flash_loader_if.sv
// rtl/flash_loader_if.sv - flash driver read port and RAM write port seen by the boot copy engine
interface flash_loader_if
    import flash_loader_pkg::*;
#(
    parameter int RAM_AW = 20
) ();

    logic [FLASH_AW-1:0] fl_addr;
    logic                fl_enable_read;
    logic [15:0]         fl_data;
    logic                fl_busy;
    logic [RAM_AW-1:0]   ram_addr;
    logic [15:0]         ram_data;
    logic                ram_we;
    logic                ram_ready;

    modport master (
        output fl_addr, fl_enable_read, ram_addr, ram_data, ram_we,
        input  fl_data, fl_busy, ram_ready
    );

    modport slave (
        input  fl_addr, fl_enable_read, ram_addr, ram_data, ram_we,
        output fl_data, fl_busy, ram_ready
    );

endinterface

// File: rtl/flash_loader_wbuf.sv
// rtl/flash_loader_wbuf.sv - one-entry write buffer holding a captured flash word until the RAM accepts it
module flash_loader_wbuf #(
    parameter int RAM_AW = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [RAM_AW-1:0] dst_base,
    input  logic              capture,
    input  logic [15:0]       cap_data,
    input  logic              ram_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [15:0]       ram_data,
    output logic              ram_we,
    output logic              buf_valid
);

    logic wr_done;

    assign wr_done = buf_valid && ram_ready;
    assign ram_we  = buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_data  <= '0;
            buf_valid <= 1'b0;
        end else begin
            if (load) begin
                ram_addr <= dst_base;
            end else if (wr_done) begin
                ram_addr <= ram_addr + RAM_AW'(1);
            end
            // A capture refills the entry in the same cycle the old word drains.
            if (capture) begin
                ram_data  <= cap_data;
                buf_valid <= 1'b1;
            end else if (wr_done) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - boot copy engine, flash to RAM; FLASH_LOADER_CHECKSUM_EN adds a running word checksum
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int RAM_AW  = 20,
    parameter int COUNT_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [FLASH_AW-1:0] src_base,
    input  logic [RAM_AW-1:0]   dst_base,
    input  logic [COUNT_W-1:0]  word_count,
    output logic                busy,
    output logic                done,
`ifdef FLASH_LOADER_CHECKSUM_EN
    output logic [15:0]         checksum,
`endif
    flash_loader_if.master      bus
);

    state_t              state;
    logic [FLASH_AW-1:0] src_ptr;
    logic [COUNT_W-1:0]  remaining;
    logic                buf_valid;
    logic                buf_free;
    logic                rd_complete;
    logic                capture;
    logic                last_word;
    logic                load;

    assign load        = (state == IDLE) && start;
    assign rd_complete = (state == READ) && !bus.fl_busy;
    assign buf_free    = !buf_valid || bus.ram_ready;
    assign capture     = rd_complete && buf_free;
    assign last_word   = capture && (remaining == COUNT_W'(1));

    // Dropping the enable in the last capture cycle keeps the driver from starting a surplus read.
    assign bus.fl_addr        = src_ptr;
    assign bus.fl_enable_read = (state == ISSUE) || ((state == READ) && !last_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_ptr   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr   <= src_base;
                        remaining <= word_count;
                        busy      <= 1'b1;
                        if (word_count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= READ;
                READ: begin
                    if (capture) begin
                        src_ptr   <= src_ptr + FLASH_AW'(1);
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!buf_valid) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    flash_loader_wbuf #(
        .RAM_AW (RAM_AW)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dst_base  (dst_base),
        .capture   (capture),
        .cap_data  (bus.fl_data),
        .ram_ready (bus.ram_ready),
        .ram_addr  (bus.ram_addr),
        .ram_data  (bus.ram_data),
        .ram_we    (bus.ram_we),
        .buf_valid (buf_valid)
    );

`ifdef FLASH_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (load) begin
            checksum <= '0;
        end else if (capture) begin
            checksum <= checksum + bus.fl_data;
        end
    end
`endif

endmodule

// File: tb/tb_flash_loader.sv
// tb/tb_flash_loader.sv - directed bench with flash driver model and RAM write scoreboard for flash_loader
`timescale 1ns/1ps
module tb_flash_loader;

    localparam int RAM_AW  = 20;
    localparam int COUNT_W = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [22:0]        src_base = '0;
    logic [RAM_AW-1:0]  dst_base = '0;
    logic [COUNT_W-1:0] word_count = '0;
    logic               busy;
    logic               done;
    logic               ram_ready_tb = 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [15:0]        checksum;
`endif

    flash_loader_if #(.RAM_AW(RAM_AW)) bus ();

    flash_loader #(
        .RAM_AW  (RAM_AW),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
`ifdef FLASH_LOADER_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int we_cnt = 0;
    int en_cnt = 0;
    int first_we_cyc = -1;
    int start_cyc = 0;
    bit csum_mode = 1'b0;

    typedef struct packed {
        logic [RAM_AW-1:0] a;
        logic [15:0]       d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         got_log[$];
    logic [22:0] read_log[$];
    logic [15:0] exp_sum = '0;

    function automatic logic [15:0] flash_word(input logic [22:0] a);
        if (csum_mode) begin
            case (a[1:0])
                2'd0:    return 16'hFFFF;
                2'd1:    return 16'h0002;
                default: return 16'h1000;
            endcase
        end
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash driver: idle, three busy cycles, then one not-busy cycle with data.
    int          drv_st = 0;
    logic [22:0] drv_addr = '0;
    always @(posedge clk) begin
        case (drv_st)
            0: if (bus.fl_enable_read) drv_st <= 1;
            1: begin
                drv_addr <= bus.fl_addr;
                read_log.push_back(bus.fl_addr);
                drv_st <= 2;
            end
            2: drv_st <= 3;
            3: drv_st <= 4;
            default: drv_st <= bus.fl_enable_read ? 1 : 0;
        endcase
    end
    assign bus.fl_busy   = !(drv_st == 0 || drv_st == 4);
    assign bus.fl_data   = (drv_st == 4) ? flash_word(drv_addr) : 16'hDEAD;
    assign bus.ram_ready = ram_ready_tb;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (bus.fl_enable_read) en_cnt++;
            if (bus.ram_we && bus.ram_ready) begin
                wr_t e;
                we_cnt++;
                got_log.push_back({bus.ram_addr, bus.ram_data});
                if (first_we_cyc < 0) first_we_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("ram_addr", 32'(bus.ram_addr), 32'(e.a));
                    chk("ram_data", 32'(bus.ram_data), 32'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_pending_words", 32'(exp_q.size()), 0);
`ifdef FLASH_LOADER_CHECKSUM_EN
                chk("checksum_model", 32'(checksum), 32'(exp_sum));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [22:0] s, input logic [RAM_AW-1:0] d,
                        input logic [COUNT_W-1:0] n, input bit expect_run);
        src_base   = s;
        dst_base   = d;
        word_count = n;
        start      = 1'b1;
        if (expect_run) begin
            exp_sum   = '0;
            start_cyc = cyc + 1;
            for (int i = 0; i < int'(n); i++) begin
                wr_t e;
                e.a = RAM_AW'(d + RAM_AW'(i));
                e.d = flash_word(23'(s + 23'(i)));
                exp_q.push_back(e);
                exp_sum = exp_sum + e.d;
            end
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int c0 = done_cnt;
        int i  = 0;
        while (done_cnt == c0 && i < budget) begin
            tick();
            i++;
        end
        chk(name, 32'(done_cnt != c0), 1);
    endtask

    task automatic check_reads(input string name, input logic [22:0] exp_a[4]);
        logic [22:0] dd[$];
        foreach (read_log[k]) begin
            if (dd.size() == 0 || dd[dd.size()-1] != read_log[k]) dd.push_back(read_log[k]);
        end
        chk({name, "_count"}, 32'(dd.size()), 4);
        for (int k = 0; k < 4 && k < dd.size(); k++) chk(name, 32'(dd[k]), 32'(exp_a[k]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, we0, en0, i, dups;
        logic [15:0] lit_d[4];
        logic [22:0] rd_exp[4];

        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_en", 32'(bus.fl_enable_read), 0);
        chk("rst_we", 32'(bus.ram_we), 0);
        chk("rst_ram_addr", 32'(bus.ram_addr), 0);
        chk("rst_fl_addr", 32'(bus.fl_addr), 0);
        tick();
        rst = 1'b0;
        tick();

        // Basic copy, pinned against hand-computed words.
        got_log.delete();
        first_we_cyc = -1;
        d0 = done_cnt;
        kick(23'h000100, 20'h00200, 4, 1);
        wait_done("basic_done", 200);
        repeat (5) tick();
        chk("basic_one_done", 32'(done_cnt - d0), 1);
        chk("basic_latency", 32'(first_we_cyc - start_cyc), 6);
        chk("basic_busy_after", 32'(busy), 0);
        lit_d = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};
        chk("basic_nwrites", 32'(got_log.size()), 4);
        for (int k = 0; k < 4 && k < got_log.size(); k++) begin
            chk("basic_lit_addr", 32'(got_log[k].a), 32'h200 + 32'(k));
            chk("basic_lit_data", 32'(got_log[k].d), 32'(lit_d[k]));
        end

        // Zero-length transfer.
        en0 = en_cnt;
        we0 = we_cnt;
        kick(23'h000040, 20'h00010, 0, 1);
        wait_done("zero_done", 20);
        chk("zero_done_cycle", 32'(done_cyc - start_cyc), 1);
        chk("zero_no_read", 32'(en_cnt - en0), 0);
        chk("zero_no_write", 32'(we_cnt - we0), 0);
        tick();

        // Back-pressure: RAM stalls for 6 cycles after the first capture.
        read_log.delete();
        we0 = we_cnt;
        kick(23'h002000, 20'h00400, 8, 1);
        i = 0;
        while (!bus.ram_we && i < 100) begin
            tick();
            i++;
        end
        chk("bp_first_we", 32'(bus.ram_we), 1);
        ram_ready_tb = 1'b0;
        repeat (6) tick();
        ram_ready_tb = 1'b1;
        wait_done("bp_done", 400);
        chk("bp_writes", 32'(we_cnt - we0), 8);
        dups = 0;
        for (int k = 1; k < read_log.size(); k++) if (read_log[k] == read_log[k-1]) dups++;
        chk("bp_reread_seen", 32'(dups > 0), 1);
        tick();

        // Reset in the middle of a transfer.
        we0 = we_cnt;
        kick(23'h000300, 20'h00500, 8, 1);
        i = 0;
        while (we_cnt - we0 < 3 && i < 300) begin
            tick();
            i++;
        end
        chk("mid_three_words", 32'(we_cnt - we0), 3);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_en", 32'(bus.fl_enable_read), 0);
        chk("mid_rst_we", 32'(bus.ram_we), 0);
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        repeat (12) tick();
        chk("mid_no_done", 32'(done_cnt - d0), 0);
        kick(23'h000310, 20'h00600, 3, 1);
        wait_done("mid_restart_done", 200);
        tick();

        // Second start while busy is ignored.
        we0 = we_cnt;
        d0  = done_cnt;
        kick(23'h000010, 20'h00700, 4, 1);
        repeat (3) tick();
        kick(23'h005000, 20'h00123, 9, 0);
        wait_done("guard_done", 200);
        repeat (4) tick();
        chk("guard_writes", 32'(we_cnt - we0), 4);
        chk("guard_one_done", 32'(done_cnt - d0), 1);

        // Source and destination wrap.
        read_log.delete();
        kick(23'h7FFFFE, 20'hFFFFE, 4, 1);
        wait_done("wrap_done", 200);
        rd_exp = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
        check_reads("wrap_read_addr", rd_exp);
        tick();

`ifdef FLASH_LOADER_CHECKSUM_EN
        csum_mode = 1'b1;
        kick(23'h000000, 20'h00800, 3, 1);
        wait_done("csum_done", 200);
        chk("csum_literal", 32'(checksum), 32'h1001);
        csum_mode = 1'b0;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
